// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

  // Number of registers selected by a 16-bit register mask.
  function automatic logic [4:0] popcount16(input logic [15:0] mask);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, mask[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Memory-side bus of the sequencer: one request/ready handshake per word.
interface ldm_stm_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a 16-bit mask.
module lowest_set_bit (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer.
//
//   state | meaning
//   IDLE  | waiting for start; request fields captured on start
//   XFER  | one memory access per remaining register, lowest index first
//   WB    | single-cycle base register writeback
//   FIN   | single-cycle done pulse, then back to IDLE
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic [15:0]       reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [3:0]        base_reg,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  output logic              busy,
  output logic              done,
  ldm_stm_sequencer_if.master mem,
  output logic [3:0]        rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [3:0]        rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

  state_t            state_q, state_d;
  logic [15:0]       mask_q, mask_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              load_q, load_d;
  logic [3:0]        base_reg_q, base_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              do_wb_q, do_wb_d;

  logic [3:0]        cur_reg;
  logic              cur_valid;
  logic [15:0]       mask_clr;
  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] first_addr;
  logic              xfer;
  logic              ld_wr;
  logic              wb_wr;

  lowest_set_bit u_lsb (
    .mask  (mask_q),
    .idx   (cur_reg),
    .valid (cur_valid)
  );

  // Request decode: total byte span of the list and the address of the first word.
  always_comb begin
    span = DATA_W'(popcount16(reg_list)) * STEP;
    unique case ({up, pre})
      2'b10:   first_addr = base_addr;
      2'b11:   first_addr = base_addr + STEP;
      2'b00:   first_addr = base_addr - span + STEP;
      default: first_addr = base_addr - span;
    endcase
  end

  assign mask_clr = mask_q & ~(16'd1 << cur_reg);

  // Next-state and datapath update; the current register is the lowest bit left in the mask.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    load_d     = load_q;
    base_reg_d = base_reg_q;
    wb_data_d  = wb_data_q;
    do_wb_d    = do_wb_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load_d     = load;
          mask_d     = reg_list;
          addr_d     = first_addr;
          base_reg_d = base_reg;
          wb_data_d  = up ? (base_addr + span) : (base_addr - span);
          // A loaded base register wins over the writeback value.
          do_wb_d    = writeback && !(load && reg_list[base_reg]);
          state_d    = (reg_list != 16'd0) ? XFER : FIN;
        end
      end
      XFER: begin
        if (!cur_valid) begin
          state_d = FIN;
        end else if (mem.mem_ready) begin
          mask_d = mask_clr;
          addr_d = addr_q + STEP;
          if (mask_clr == 16'd0) begin
            state_d = do_wb_q ? WB : FIN;
          end
        end
      end
      WB:      state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      addr_q     <= '0;
      load_q     <= 1'b0;
      base_reg_q <= '0;
      wb_data_q  <= '0;
      do_wb_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      load_q     <= load_d;
      base_reg_q <= base_reg_d;
      wb_data_q  <= wb_data_d;
      do_wb_q    <= do_wb_d;
    end
  end

  // Strobes are also masked by reset so an abort never lets a final access or write slip out.
  assign xfer  = (state_q == XFER) && cur_valid;
  assign ld_wr = xfer && load_q && mem.mem_ready;
  assign wb_wr = (state_q == WB);

  assign mem.mem_req   = xfer && reset;
  assign mem.mem_we    = xfer && !load_q;
  assign mem.mem_addr  = xfer ? addr_q : '0;
  assign mem.mem_wdata = (xfer && !load_q) ? rf_read_data : '0;
  assign rf_read_reg   = (xfer && !load_q) ? cur_reg : 4'd0;

  assign rf_write_en   = (ld_wr || wb_wr) && reset;
  assign rf_write_reg  = ld_wr ? cur_reg : (wb_wr ? base_reg_q : 4'd0);
  assign rf_write_data = ld_wr ? mem.mem_rdata : (wb_wr ? wb_data_q : '0);

  assign busy = (state_q == XFER) || (state_q == WB);
  assign done = (state_q == FIN);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: vector table plus event scoreboard.
module tb_ldm_stm_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        load;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [3:0]  base_reg;
  logic        up, pre, writeback;
  logic        busy, done;
  logic [3:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        rf_write_en;
  logic [3:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  ldm_stm_sequencer_if #(.DATA_W(32)) mem_if ();

  ldm_stm_sequencer #(.DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .load          (load),
    .reg_list      (reg_list),
    .base_addr     (base_addr),
    .base_reg      (base_reg),
    .up            (up),
    .pre           (pre),
    .writeback     (writeback),
    .busy          (busy),
    .done          (done),
    .mem           (mem_if),
    .rf_read_reg   (rf_read_reg),
    .rf_read_data  (rf_read_data),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rf_val(input logic [3:0] r);
    return 32'hA5A5_0000 | ({28'd0, r} * 32'h0000_0101);
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  assign rf_read_data     = rf_val(rf_read_reg);
  assign mem_if.mem_rdata = mem_val(mem_if.mem_addr);

  typedef struct {
    logic        ld;
    logic [15:0] list;
    logic [31:0] base;
    logic [3:0]  breg;
    logic        u, p, w;
    logic [31:0] exp_first;
    int          exp_done;
  } vec_t;

  typedef struct {
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rfw;
    logic [3:0]  wreg;
    logic [31:0] wdat;
  } ev_t;

  vec_t vecs[7];
  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected accesses/writes of one request, in order.
  task automatic push_model(input vec_t v);
    int n;
    logic [31:0] a;
    ev_t e;
    n = 0;
    for (int i = 0; i < 16; i++) if (v.list[i]) n++;
    if (v.u) a = v.base + (v.p ? 32'd4 : 32'd0);
    else     a = v.base - 32'(4 * n) + (v.p ? 32'd0 : 32'd4);
    for (int i = 0; i < 16; i++) begin
      if (v.list[i]) begin
        e.mem   = 1'b1;
        e.we    = !v.ld;
        e.addr  = a;
        e.wdata = v.ld ? 32'd0 : rf_val(4'(i));
        e.rfw   = v.ld;
        e.wreg  = 4'(i);
        e.wdat  = v.ld ? mem_val(a) : 32'd0;
        exp_q.push_back(e);
        a = a + 32'd4;
      end
    end
    if (v.w && n > 0 && !(v.ld && v.list[v.breg])) begin
      e.mem   = 1'b0;
      e.we    = 1'b0;
      e.addr  = 32'd0;
      e.wdata = 32'd0;
      e.rfw   = 1'b1;
      e.wreg  = v.breg;
      e.wdat  = v.u ? v.base + 32'(4 * n) : v.base - 32'(4 * n);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: every accepted access or register write must match the next expected event.
  always @(negedge clock) begin
    logic act_mem;
    ev_t  e;
    act_mem = mem_if.mem_req && mem_if.mem_ready;
    if (mon_en && (act_mem || rf_write_en)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: mem=%b addr=%h rf_we=%b reg=%0d expected none",
                 act_mem, mem_if.mem_addr, rf_write_en, rf_write_reg);
      end else begin
        e = exp_q.pop_front();
        check("ev_mem", 32'(act_mem), 32'(e.mem));
        if (e.mem) begin
          check("ev_addr", mem_if.mem_addr, e.addr);
          check("ev_we", 32'(mem_if.mem_we), 32'(e.we));
          if (e.we) check("ev_wdata", mem_if.mem_wdata, e.wdata);
        end
        check("ev_rf_we", 32'(rf_write_en), 32'(e.rfw));
        if (e.rfw) begin
          check("ev_rf_reg", 32'(rf_write_reg), 32'(e.wreg));
          check("ev_rf_data", rf_write_data, e.wdat);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_if.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_if.mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_if.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_if.mem_wdata, 32'd0);
    check({tag, "_rf_read_reg"}, 32'(rf_read_reg), 32'd0);
    check({tag, "_rf_we"}, 32'(rf_write_en), 32'd0);
    check({tag, "_rf_wreg"}, 32'(rf_write_reg), 32'd0);
    check({tag, "_rf_wdata"}, rf_write_data, 32'd0);
  endtask

  task automatic apply_req(input vec_t v);
    load      = v.ld;
    reg_list  = v.list;
    base_addr = v.base;
    base_reg  = v.breg;
    up        = v.u;
    pre       = v.p;
    writeback = v.w;
  endtask

  // Launch one request with mem_ready held high and track it to its done pulse.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit got;
    @(posedge clock); #1;
    apply_req(v);
    start = 1'b1;
    push_model(v);
    @(posedge clock); #1;
    start     = 1'b0;
    reg_list  = 16'($urandom);
    base_addr = $urandom;
    base_reg  = 4'($urandom);
    load      = 1'($urandom);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1 && v.list != 16'd0) check($sformatf("v%0d_first_addr", idx), mem_if.mem_addr, v.exp_first);
      check($sformatf("v%0d_busy_c%0d", idx, cyc), 32'(busy), 32'(cyc < v.exp_done));
      check($sformatf("v%0d_done_c%0d", idx, cyc), 32'(done), 32'(cyc == v.exp_done));
      if (done) begin
        got = 1'b1;
        check($sformatf("v%0d_fin_mem_req", idx), 32'(mem_if.mem_req), 32'd0);
        check($sformatf("v%0d_fin_rf_we", idx), 32'(rf_write_en), 32'd0);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d_done_timeout: no done after %0d cycles, expected at %0d", idx, cyc, v.exp_done);
    end
    @(negedge clock);
    check($sformatf("v%0d_post_done", idx), 32'(done), 32'd0);
    check($sformatf("v%0d_post_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_events_left", idx), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int   cyc;
    bit   got;
    vec_t sv;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    bit   got;
    vec_t sv;

    //          ld    list       base           breg   u     p     w     first          done
    vecs[0] = '{1'b0, 16'h000E, 32'h0000_0100, 4'd13, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 5};
    vecs[1] = '{1'b1, 16'h8001, 32'h0000_0200, 4'd13, 1'b0, 1'b1, 1'b0, 32'h0000_01F8, 3};
    vecs[2] = '{1'b1, 16'h0030, 32'h0000_0300, 4'd5,  1'b1, 1'b1, 1'b1, 32'h0000_0304, 3};
    vecs[3] = '{1'b0, 16'h0000, 32'h0000_0400, 4'd1,  1'b1, 1'b0, 1'b1, 32'h0000_0000, 1};
    vecs[4] = '{1'b0, 16'h0101, 32'h0000_0040, 4'd2,  1'b0, 1'b0, 1'b1, 32'h0000_003C, 4};
    vecs[5] = '{1'b1, 16'hFFFF, 32'h0000_0000, 4'd3,  1'b0, 1'b1, 1'b1, 32'hFFFF_FFC0, 17};
    vecs[6] = '{1'b0, 16'h8001, 32'hFFFF_FFFC, 4'd0,  1'b1, 1'b1, 1'b1, 32'h0000_0000, 4};

    reset = 1'b0;
    start = 1'b0;
    load = 1'b0; reg_list = '0; base_addr = '0; base_reg = '0;
    up = 1'b0; pre = 1'b0; writeback = 1'b0;
    mem_if.mem_ready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("rst");
    @(posedge clock); #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // mem_ready low for three cycles on the second STM word.
    sv = '{1'b0, 16'h000E, 32'h0000_0100, 4'd13, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 7};
    @(posedge clock); #1;
    apply_req(sv);
    start = 1'b1;
    push_model(sv);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("stall_first_addr", mem_if.mem_addr, 32'h0000_0100);
    @(posedge clock); #1;
    mem_if.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_mem_req", 32'(mem_if.mem_req), 32'd1);
      check("stall_mem_addr", mem_if.mem_addr, 32'h0000_0104);
      check("stall_mem_wdata", mem_if.mem_wdata, rf_val(4'd2));
      check("stall_rf_read_reg", 32'(rf_read_reg), 32'd2);
      @(posedge clock); #1;
    end
    mem_if.mem_ready = 1'b1;
    cyc = 4;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (done) got = 1'b1;
    end
    check("stall_done_cycle", 32'(cyc), 32'd7);
    @(negedge clock);
    check("stall_events_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset during the second transfer with a stray start while busy.
    sv = '{1'b0, 16'h000E, 32'h0000_0500, 4'd9, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 5};
    @(posedge clock); #1;
    apply_req(sv);
    start = 1'b1;
    push_model(sv);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("abort_first_addr", mem_if.mem_addr, 32'h0000_0500);
    @(posedge clock); #1;
    mem_if.mem_ready = 1'b0;
    start     = 1'b1;
    load      = 1'b1;
    reg_list  = 16'hFFFF;
    base_addr = 32'h0000_0900;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_second_addr", mem_if.mem_addr, 32'h0000_0504);
    check("abort_still_store", 32'(mem_if.mem_we), 32'd1);
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("abort_rst_rf_we", 32'(rf_write_en), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    mem_if.mem_ready = 1'b1;
    @(negedge clock);
    check_all_zero("abort");
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("abort_idle_done", 32'(done), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);
    end
    check("abort_events_left", 32'(exp_q.size()), 32'd0);

    run_vec(vecs[0], 7);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
